// File: rtl/instruction_fetch_mem_pkg.sv
// Shared fetch-side types: FSM states, response payload, fault constant and
// the address fault predicate used by both the memory and PC-side logic.
package instruction_fetch_mem_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] FAULT_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic            err;
        logic [XLEN-1:0] instr;
    } fetch_resp_t;

    // Misaligned or beyond the end of memory; plain unsigned compare, no wrap.
    function automatic logic fetch_fault(input logic [XLEN-1:0] addr,
                                         input logic [XLEN-1:0] mem_bytes);
        return (addr[1:0] != 2'b00) || (addr >= mem_bytes);
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction word storage: one synchronous write port, one combinational
// read port. Contents are intentionally not reset.
module imem_array
    import instruction_fetch_mem_pkg::*;
#(
    parameter  int unsigned WORDS = 256,
    localparam int unsigned AW    = $clog2(WORDS)
)(
    input  logic            clock,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [XLEN-1:0] rdata_c
);

    logic [XLEN-1:0] mem [WORDS];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/instruction_fetch_mem.sv
// Fixed-latency instruction fetch memory: accepts one request at a time,
// answers LATENCY edges later and holds the response until consumed.
module instruction_fetch_mem
    import instruction_fetch_mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned LATENCY   = 2
)(
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_instr,
    output logic            resp_err,
    input  logic            load_en,
    input  logic [XLEN-1:0] load_addr,
    input  logic [XLEN-1:0] load_data
);

    localparam int unsigned     WORDS     = MEM_BYTES / 4;
    localparam int unsigned     BYTE_AW   = $clog2(MEM_BYTES);
    localparam int unsigned     CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [XLEN-1:0]  MEM_LIMIT = XLEN'(MEM_BYTES);

    fetch_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    fetch_resp_t      cap_q, cap_d;
    logic             req_ready_d;
    logic             resp_valid_d;
    fetch_resp_t      resp_d;

    logic [XLEN-1:0]  rd_word_c;
    logic             fault_c;
    logic             load_we_c;

    // Loads are dropped while in reset and when they fall outside the array.
    assign load_we_c = load_en && !reset && (load_addr < MEM_LIMIT);
    assign fault_c   = fetch_fault(req_addr, MEM_LIMIT);

    imem_array #(
        .WORDS (WORDS)
    ) u_imem_array (
        .clock   (clock),
        .we      (load_we_c),
        .waddr   (load_addr[BYTE_AW-1:2]),
        .wdata   (load_data),
        .raddr   (req_addr[BYTE_AW-1:2]),
        .rdata_c (rd_word_c)
    );

    // Next state; the word is captured from the pre-write array contents.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cap_d        = cap_q;
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_d       = '0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d     = WAIT;
                    cnt_d       = CNT_LOAD;
                    cap_d.err   = fault_c;
                    cap_d.instr = fault_c ? FAULT_INSTR : rd_word_c;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
        if (state_d == RESP) begin
            resp_d = cap_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cap_q      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_instr <= '0;
            resp_err   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cap_q      <= cap_d;
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_instr <= resp_d.instr;
            resp_err   <= resp_d.err;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_mem.sv
// Directed bench for instruction_fetch_mem with a timeline model of the
// request/response protocol checked every cycle, plus literal expectations.
module tb_instruction_fetch_mem;

    localparam int unsigned LAT  = 2;
    localparam int unsigned MEMB = 1024;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_instr;
    logic        resp_err;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;

    logic        req_valid1 = 1'b0;
    logic        req_ready1;
    logic [31:0] req_addr1 = '0;
    logic        resp_valid1;
    logic        resp_ready1 = 1'b1;
    logic [31:0] resp_instr1;
    logic        resp_err1;
    logic        load_en1 = 1'b0;
    logic [31:0] load_addr1 = '0;
    logic [31:0] load_data1 = '0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    instruction_fetch_mem #(.MEM_BYTES(MEMB), .LATENCY(LAT)) u_dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_instr (resp_instr),
        .resp_err   (resp_err),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data)
    );

    instruction_fetch_mem #(.MEM_BYTES(64), .LATENCY(1)) u_dut_lat1 (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid1),
        .req_ready  (req_ready1),
        .req_addr   (req_addr1),
        .resp_valid (resp_valid1),
        .resp_ready (resp_ready1),
        .resp_instr (resp_instr1),
        .resp_err   (resp_err1),
        .load_en    (load_en1),
        .load_addr  (load_addr1),
        .load_data  (load_data1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: memory image plus one outstanding fetch, due at an absolute edge count.
    logic [31:0] mm [256];
    bit          busy = 1'b0;
    int          edge_n = 0;
    int          due = 0;
    logic [31:0] exp_instr = '0;
    logic        exp_err = 1'b0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            busy = 1'b0;
        end else begin
            if (busy && edge_n >= due) begin
                if (resp_ready) busy = 1'b0;
            end else if (!busy && req_valid) begin
                busy      = 1'b1;
                exp_err   = (req_addr % 4 != 0) || (req_addr >= MEMB);
                exp_instr = exp_err ? 32'h0 : mm[req_addr / 4];
                due       = edge_n + 1 + int'(LAT);
            end
            if (load_en && load_addr < MEMB) mm[load_addr / 4] = load_data;
            edge_n++;
        end
    end

    always @(negedge clock) begin
        if (!(busy == 1'b0 && edge_n == 0 && !reset && $time < 2)) begin
            check("m_req_ready",  req_ready,  !busy);
            check("m_resp_valid", resp_valid, busy && edge_n >= due);
            check("m_resp_instr", resp_instr, (busy && edge_n >= due) ? exp_instr : 32'h0);
            check("m_resp_err",   resp_err,   busy && edge_n >= due && exp_err);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic do_fetch(input string name, input logic [31:0] a, input int stall,
                            input bit do_ld, input logic [31:0] la, input logic [31:0] ld,
                            input logic [31:0] e_instr, input logic e_err);
        int  n;
        bit  acc;
        resp_ready = (stall == 0);
        req_valid  = 1'b1;
        req_addr   = a;
        if (do_ld) begin
            load_en = 1'b1; load_addr = la; load_data = ld;
        end
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = req_ready;
            tick();
            load_en = 1'b0;
        end
        req_valid = 1'b0;
        check({name, "_accept"}, 32'(acc), 32'd1);
        n = 0;
        while (!resp_valid && n < 50) begin
            tick();
            n++;
        end
        check({name, "_latency"}, n, LAT);
        check({name, "_instr"}, resp_instr, e_instr);
        check({name, "_err"}, 32'(resp_err), 32'(e_err));
        for (int i = 0; i < stall; i++) begin
            tick();
            check({name, "_stall_valid"}, 32'(resp_valid), 32'd1);
            check({name, "_stall_instr"}, resp_instr, e_instr);
            check({name, "_stall_ready"}, 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        tick();
        check({name, "_done_valid"}, 32'(resp_valid), 32'd0);
        check({name, "_done_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mm[i] = '0;
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("reset_req_ready",  32'(req_ready),  32'd1);
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_resp_instr", resp_instr,      32'h0);
        reset = 1'b0;
        tick();

        load_word(32'h0,   32'h2008_0005);
        load_word(32'h4,   32'h2109_0003);
        load_word(32'h8,   32'h1111_1111);
        load_word(32'h10,  32'h3333_3333);
        load_word(32'h3FC, 32'hCAFE_F00D);
        load_word(32'h404, 32'hDEAD_BEEF);

        do_fetch("f000", 32'h0,         0, 1'b0, 32'h0, 32'h0, 32'h2008_0005, 1'b0);
        do_fetch("f004", 32'h4,         0, 1'b0, 32'h0, 32'h0, 32'h2109_0003, 1'b0);
        do_fetch("f002", 32'h2,         0, 1'b0, 32'h0, 32'h0, 32'h0,         1'b1);
        do_fetch("f400", 32'h400,       0, 1'b0, 32'h0, 32'h0, 32'h0,         1'b1);
        do_fetch("ftop", 32'hFFFF_FFFC, 0, 1'b0, 32'h0, 32'h0, 32'h0,         1'b1);
        do_fetch("f3fc", 32'h3FC,       0, 1'b0, 32'h0, 32'h0, 32'hCAFE_F00D, 1'b0);
        do_fetch("fstl", 32'h8,         5, 1'b0, 32'h0, 32'h0, 32'h1111_1111, 1'b0);
        do_fetch("frbw", 32'h8,         0, 1'b1, 32'h8, 32'h2222_2222, 32'h1111_1111, 1'b0);
        do_fetch("fnew", 32'h8,         0, 1'b0, 32'h0, 32'h0, 32'h2222_2222, 1'b0);

        // Reset while the fetch is waiting; a load under reset must be dropped.
        req_valid = 1'b1; req_addr = 32'h4;
        tick();
        req_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_wait_valid", 32'(resp_valid), 32'd0);
        check("rst_wait_ready", 32'(req_ready),  32'd1);
        load_en = 1'b1; load_addr = 32'h10; load_data = 32'hDEAD_0000;
        tick();
        load_en = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_valid", 32'(resp_valid), 32'd0);
            check("post_rst_ready", 32'(req_ready),  32'd1);
        end
        do_fetch("fr10", 32'h10, 0, 1'b0, 32'h0, 32'h0, 32'h3333_3333, 1'b0);
        do_fetch("fr00", 32'h0,  0, 1'b0, 32'h0, 32'h0, 32'h2008_0005, 1'b0);

        // Single-cycle latency instance.
        load_en1 = 1'b1; load_addr1 = 32'h3C; load_data1 = 32'hABCD_0001;
        tick();
        load_en1 = 1'b0;
        check("l1_ready", 32'(req_ready1), 32'd1);
        req_valid1 = 1'b1; req_addr1 = 32'h3C;
        tick();
        req_valid1 = 1'b0;
        check("l1_wait_valid", 32'(resp_valid1), 32'd0);
        tick();
        check("l1_valid", 32'(resp_valid1), 32'd1);
        check("l1_instr", resp_instr1, 32'hABCD_0001);
        check("l1_err",   32'(resp_err1), 32'd0);
        tick();
        check("l1_done_valid", 32'(resp_valid1), 32'd0);
        check("l1_done_ready", 32'(req_ready1),  32'd1);
        req_valid1 = 1'b1; req_addr1 = 32'h40;
        tick();
        req_valid1 = 1'b0;
        tick();
        check("l1_oob_valid", 32'(resp_valid1), 32'd1);
        check("l1_oob_err",   32'(resp_err1),   32'd1);
        check("l1_oob_instr", resp_instr1,      32'h0);
        tick();

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_mem.md
INSTRUCTION_FETCH_MEM -- requirements
Module: instruction_fetch_mem

Interface
REQ-001 Parameter MEM_BYTES, default 1024: memory size in bytes; SHALL be a power of two and at least 8.
REQ-002 Parameter LATENCY, default 2: number of cycles from request acceptance to response valid; SHALL be at least 1.
REQ-003 Port: clock  input  1  single clock, all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: req_valid  input  1  fetch request from the PC side.
REQ-006 Port: req_ready  output  1  block can accept a request this cycle.
REQ-007 Port: req_addr  input  32  byte address of the fetch, as driven by the PC.
REQ-008 Port: resp_valid  output  1  response present.
REQ-009 Port: resp_ready  input  1  consumer accepts the response.
REQ-010 Port: resp_instr  output  32  fetched instruction word.
REQ-011 Port: resp_err  output  1  fetch fault (misaligned or out of range).
REQ-012 Port: load_en  input  1  memory preload write strobe.
REQ-013 Port: load_addr  input  32  byte address of the preload word; bits [1:0] are ignored.
REQ-014 Port: load_data  input  32  preload word.

Function
REQ-015 Storage SHALL be MEM_BYTES/4 32-bit words, indexed by address bits [log2(MEM_BYTES)-1:2].
REQ-016 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-017 req_ready SHALL be 1 only in IDLE.
REQ-018 A request is accepted on a rising edge where req_valid=1 and req_ready=1; acceptance moves the FSM IDLE->WAIT and loads the wait counter with LATENCY-1.
REQ-019 In WAIT, the counter SHALL decrement each cycle; WAIT->RESP occurs on the edge where the counter is 0.
- Net effect: resp_valid rises exactly LATENCY edges after the accepting edge.
REQ-020 At acceptance the block SHALL capture the instruction word and the error flag.
- Later load writes SHALL NOT alter an in-flight response.
REQ-021 A load write on the same edge as acceptance to the same word SHALL give read-before-write: the response carries the old word.
REQ-022 resp_err SHALL be 1 if req_addr[1:0]!=0 or req_addr>=MEM_BYTES.
- When resp_err=1, resp_instr SHALL be 32'h0000_0000.
- Faulted requests SHALL use the same latency as normal requests.
REQ-023 In RESP, resp_valid, resp_instr and resp_err SHALL be held stable until resp_ready=1.
REQ-024 On the edge where resp_valid=1 and resp_ready=1, the FSM SHALL go RESP->IDLE.
- resp_valid=0 and req_ready=1 on the following cycle; there is no back-to-back bypass.
REQ-025 Outside RESP, resp_valid SHALL be 0 and resp_instr/resp_err SHALL be 0.
REQ-026 load_en SHALL write load_data on any rising edge, in any FSM state.
- Out-of-range load_addr (>=MEM_BYTES) SHALL be ignored.
REQ-027 Word address arithmetic SHALL be unsigned 32-bit, with no wrap-around.
- For example, 32'hFFFF_FFFC is out of range, not aliased.

Reset
REQ-028 Reset assertion SHALL immediately force the FSM to IDLE, the counter to 0, and resp_valid, resp_instr and resp_err to 0.
- req_ready SHALL be 1 while reset is asserted.
REQ-029 Reset during WAIT or RESP SHALL discard the in-flight fetch; no response is produced after reset is released.
REQ-030 Reset SHALL NOT clear memory contents.
REQ-031 Load writes SHALL be ignored while reset is asserted.

Structure
REQ-032 A shared package SHALL hold the FSM state enum (IDLE/WAIT/RESP) and the fault-instruction constant 32'h0000_0000.
- The package is reused by PC-side logic.
REQ-033 The storage array SHALL be a sub-module, imem_array: one synchronous write port and one combinational read port, parameterised by word count.

Verification
REQ-034 Preload 0x0 with 0x2008_0005 and 0x4 with 0x2109_0003; fetch 0x0 then 0x4 with resp_ready=1 -> responses 0x2008_0005 then 0x2109_0003, err=0, each arriving 2 edges after acceptance.
REQ-035 Fetch 0x2 -> resp_err=1, resp_instr=0. Fetch 0x400 with MEM_BYTES=1024 -> resp_err=1.
REQ-036 Fetch 0x8 with resp_ready=0 for 5 cycles -> resp_valid and the data stay stable for the whole stall; req_ready=0 throughout; completion occurs on the edge resp_ready=1 is seen.
REQ-037 Accept a fetch of 0x8 (old word 0x1111_1111) while loading 0x8 with 0x2222_2222 on the same edge -> response 0x1111_1111; a re-fetch of 0x8 returns 0x2222_2222.
REQ-038 Assert reset in WAIT -> resp_valid stays 0 and req_ready=1 right after release; previously preloaded words remain readable.
REQ-039 With LATENCY=1, accept a fetch -> resp_valid is 1 on the next cycle.
